// File: rtl/fxp_op_scheduler_if.sv
// Request/response bundle between client logic and fxp_op_scheduler.
// Requests: two lanes packed side by side. Lane i uses req_a/req_b[i*WIDTH +: WIDTH] and req_op[2*i +: 2].
// Responses: a single valid/ready channel carrying data, requester id and error flag.
interface fxp_op_scheduler_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [3:0]         req_op;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_id;
  logic               rsp_err;

  // Client side: issues requests and consumes responses.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/fxp_op_scheduler.sv
// Purpose: shares one add/mul/div fixed-point datapath between two round-robin requesters, one op in flight.
// Latency: accept -> rsp_valid is 2 cycles for add/mul/invalid, 2 + divider cycles for div.
// Backpressure: rsp_ready low parks the FSM in RESP with the response held; req_ready is low outside IDLE.
// Ports: clk/rst_n (async active-low); bus = slave side of fxp_op_scheduler_if (req_* / rsp_*);
//        op_a/op_b/div_start drive the units; add/mul/div_result and div_complete come back; op_count
//        counts retired responses and wraps.
// Option: define FXP_SCHED_DIV_TIMEOUT_EN to abandon a divide after DIV_TIMEOUT cycles with an error
//         response; without it WAIT_DIV waits for div_complete indefinitely.
module fxp_op_scheduler #(
  parameter int WIDTH       = 32,
  parameter int DIV_TIMEOUT = 64   // must be >= 1; only consulted with the timeout option
) (
  input  logic              clk,
  input  logic              rst_n,
  fxp_op_scheduler_if.slave bus,
  output logic [WIDTH-1:0]  op_a,
  output logic [WIDTH-1:0]  op_b,
  output logic              div_start,
  input  logic [WIDTH-1:0]  add_result,
  input  logic [WIDTH-1:0]  mul_result,
  input  logic [WIDTH-1:0]  div_result,
  input  logic              div_complete,
  output logic [15:0]       op_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_DIV = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_INV = 2'b11
  } opcode_t;

  state_t           state;
  state_t           state_nxt;
  opcode_t          op_q;
  logic             rr_ptr;      // requester that wins when both are valid
  logic             id_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;

  logic             grant_vld;
  logic             grant_id;
  logic             cap_vld;     // load the response registers this cycle
  logic [WIDTH-1:0] cap_data;
  logic             cap_err;
  logic             retire;
  logic             div_wait_expired;

  // ---------------------------------------------------------------------------
  // Divide watchdog. The counter sits at zero outside WAIT_DIV, so it is clear
  // on every entry. It saturates at its last value, the cycle on which the
  // wait is abandoned unless div_complete arrives in that same cycle.
  // ---------------------------------------------------------------------------
  localparam int               TMO_W    = (DIV_TIMEOUT < 2) ? 1 : $clog2(DIV_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DIV_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_en;

  assign div_wait_expired = tmo_en && (tmo_cnt == TMO_LAST);

`ifdef FXP_SCHED_DIV_TIMEOUT_EN
  assign tmo_en = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != WAIT_DIV) begin
      tmo_cnt <= '0;
    end else if (!div_wait_expired) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_en  = 1'b0;
  assign tmo_cnt = '0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, grant and unit control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 1'b0;
    grant_vld     = 1'b0;
    grant_id      = 1'b0;
    div_start     = 1'b0;
    cap_vld       = 1'b0;
    cap_data      = '0;
    cap_err       = 1'b0;
    retire        = 1'b0;

    case (state)
      IDLE: begin
        // Contention goes to the pointer; otherwise whichever lane is valid.
        grant_id = (bus.req_valid == 2'b11) ? rr_ptr : bus.req_valid[1];
        if (|bus.req_valid) begin
          // Ready is raised only for a valid lane, so a grant is an accept.
          grant_vld     = 1'b1;
          bus.req_ready = grant_id ? 2'b10 : 2'b01;
          state_nxt     = EXEC;
        end
      end

      EXEC: begin
        // op_a/op_b were registered at accept, so the combinational unit
        // outputs are settled for the whole of this cycle.
        case (op_q)
          OP_ADD: begin
            cap_vld   = 1'b1;
            cap_data  = add_result;
            state_nxt = RESP;
          end
          OP_MUL: begin
            cap_vld   = 1'b1;
            cap_data  = mul_result;
            state_nxt = RESP;
          end
          OP_DIV: begin
            div_start = 1'b1;
            state_nxt = WAIT_DIV;
          end
          default: begin
            cap_vld   = 1'b1;
            cap_err   = 1'b1;
            state_nxt = RESP;
          end
        endcase
      end

      WAIT_DIV: begin
        // A completion in the expiry cycle still yields the real quotient.
        if (div_complete) begin
          cap_vld   = 1'b1;
          cap_data  = div_result;
          state_nxt = RESP;
        end else if (div_wait_expired) begin
          cap_vld   = 1'b1;
          cap_err   = 1'b1;
          state_nxt = RESP;
        end
      end

      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          // Returning to IDLE, rather than granting here, keeps the retire
          // cycle free of a new accept.
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand, tag and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      op_q     <= OP_ADD;
      id_q     <= 1'b0;
      rr_ptr   <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      op_count <= 16'd0;
    end else begin
      // Only the granted lane is sampled, so the other lane's fields may
      // change freely. The operands then hold until the next accept, which
      // also keeps them stable for the divider.
      if (grant_vld) begin
        op_a   <= grant_id ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
        op_b   <= grant_id ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
        op_q   <= opcode_t'(grant_id ? bus.req_op[3:2] : bus.req_op[1:0]);
        id_q   <= grant_id;
        rr_ptr <= ~grant_id;
      end
      if (cap_vld) begin
        data_q <= cap_data;
        err_q  <= cap_err;
      end
      if (retire) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

  assign bus.rsp_data = data_q;
  assign bus.rsp_id   = id_q;
  assign bus.rsp_err  = err_q;

endmodule

// File: tb/tb_fxp_op_scheduler.sv
`timescale 1ns/1ps
module tb_fxp_op_scheduler;
  localparam int W       = 32;
  localparam int DIV_LAT = 20;
  localparam int TMO     = 64;
  localparam logic [W-1:0] DIV_IDLE_VAL = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fxp_op_scheduler_if #(.WIDTH(W)) bus();

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         div_start;
  logic [W-1:0] add_result;
  logic [W-1:0] mul_result;
  logic [W-1:0] div_result   = DIV_IDLE_VAL;
  logic         div_complete = 1'b0;
  logic [15:0]  op_count;

  fxp_op_scheduler #(.WIDTH(W), .DIV_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .op_a         (op_a),
    .op_b         (op_b),
    .div_start    (div_start),
    .add_result   (add_result),
    .mul_result   (mul_result),
    .div_result   (div_result),
    .div_complete (div_complete),
    .op_count     (op_count)
  );

  // Q16.16 unit models
  assign add_result = op_a + op_b;
  assign mul_result = W'((64'(op_a) * 64'(op_b)) >> 16);

  function automatic logic [W-1:0] qdiv(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] num;
    num = {16'd0, a, 16'd0};
    if (b == '0) return '1;
    return W'(num / {32'd0, b});
  endfunction

  // Divider model: completes DIV_LAT negedges after seeing div_start; the
  // quotient is only presented in the completion cycle.
  int           div_starts = 0;
  int           dcnt       = 0;
  bit           div_auto   = 1'b1;
  logic [W-1:0] pend_res   = '0;

  always @(negedge clk) begin
    if (div_start) begin
      div_starts   <= div_starts + 1;
      pend_res     <= qdiv(op_a, op_b);
      dcnt         <= div_auto ? DIV_LAT : 0;
      div_complete <= 1'b0;
      div_result   <= DIV_IDLE_VAL;
    end else if (dcnt == 1) begin
      dcnt         <= 0;
      div_complete <= 1'b1;
      div_result   <= pend_res;
    end else begin
      if (dcnt > 0) dcnt <= dcnt - 1;
      div_complete <= 1'b0;
      div_result   <= DIV_IDLE_VAL;
    end
  end

  typedef struct {
    logic         id;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         err;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         id;
    logic         err;
  } rsp_t;

  rsp_t exp_q[$];
  vec_t vecs[8];
  int   total     = 0;
  int   bad       = 0;
  int   exp_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_req_ready"}, 64'(bus.req_ready), 64'(2'b00));
    chk({p, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(1'b0));
    chk({p, "_rsp_data"},  64'(bus.rsp_data),  64'(0));
    chk({p, "_rsp_id"},    64'(bus.rsp_id),    64'(1'b0));
    chk({p, "_rsp_err"},   64'(bus.rsp_err),   64'(1'b0));
    chk({p, "_op_a"},      64'(op_a),          64'(0));
    chk({p, "_op_b"},      64'(op_b),          64'(0));
    chk({p, "_div_start"}, 64'(div_start),     64'(1'b0));
    chk({p, "_op_count"},  64'(op_count),      64'(0));
  endtask

  task automatic apply_reset();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_count = 0;
  endtask

  task automatic drive_req(input logic id, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      bus.req_a[W +: W] = a;
      bus.req_b[W +: W] = b;
      bus.req_op[3:2]   = op;
    end else begin
      bus.req_a[0 +: W] = a;
      bus.req_b[0 +: W] = b;
      bus.req_op[1:0]   = op;
    end
    bus.req_valid[id] = 1'b1;
  endtask

  // Bounded wait for req_ready on lane id; an accept happens at the next posedge.
  task automatic wait_grant(input logic id, input string name);
    int n;
    logic [1:0] want;
    n = 0;
    want = id ? 2'b10 : 2'b01;
    while (bus.req_ready !== want && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(bus.req_ready), 64'(want));
  endtask

  // Counts negedges after the accept edge until rsp_valid (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 200);
  endtask

  task automatic check_rsp(input string name);
    rsp_t e;
    chk({name, "_vld"}, 64'(bus.rsp_valid), 64'(1'b1));
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: response with empty scoreboard", name);
      return;
    end
    e = exp_q.pop_front();
    chk({name, "_data"}, 64'(bus.rsp_data), 64'(e.data));
    chk({name, "_id"},   64'(bus.rsp_id),   64'(e.id));
    chk({name, "_err"},  64'(bus.rsp_err),  64'(e.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int s0;
    int seen;
    logic [15:0] cnt0;
    logic [1:0]  grant_seq [3];

    vecs[0] = '{id:1'b0, op:2'b00, a:32'h0001_0000, b:32'h0002_0000, data:32'h0003_0000, err:1'b0, lat:2};
    vecs[1] = '{id:1'b1, op:2'b00, a:32'hFFFF_0000, b:32'h0002_0000, data:32'h0001_0000, err:1'b0, lat:2};
    vecs[2] = '{id:1'b0, op:2'b01, a:32'h0002_0000, b:32'h0003_0000, data:32'h0006_0000, err:1'b0, lat:2};
    vecs[3] = '{id:1'b1, op:2'b01, a:32'h0000_8000, b:32'h0004_0000, data:32'h0002_0000, err:1'b0, lat:2};
    vecs[4] = '{id:1'b1, op:2'b10, a:32'h0006_0000, b:32'h0002_0000, data:32'h0003_0000, err:1'b0, lat:2 + DIV_LAT};
    vecs[5] = '{id:1'b0, op:2'b10, a:32'h0001_0000, b:32'h0004_0000, data:32'h0000_4000, err:1'b0, lat:2 + DIV_LAT};
    vecs[6] = '{id:1'b0, op:2'b11, a:32'h1234_5678, b:32'h0000_0001, data:32'h0000_0000, err:1'b1, lat:2};
    vecs[7] = '{id:1'b1, op:2'b11, a:32'h0000_0001, b:32'h8765_4321, data:32'h0000_0000, err:1'b1, lat:2};

    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = 4'b0000;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    #12;
    check_reset_vals("rst");
    apply_reset();

    // ---- table-driven single requests, idle lane gets noise ----
    for (int i = 0; i < 8; i++) begin
      s0 = div_starts;
      exp_q.push_back('{data:vecs[i].data, id:vecs[i].id, err:vecs[i].err});
      @(negedge clk);
      drive_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      if (vecs[i].id) begin
        bus.req_a[0 +: W] = $urandom;
        bus.req_b[0 +: W] = $urandom;
        bus.req_op[1:0]   = 2'($urandom_range(0, 3));
      end else begin
        bus.req_a[W +: W] = $urandom;
        bus.req_b[W +: W] = $urandom;
        bus.req_op[3:2]   = 2'($urandom_range(0, 3));
      end
      #1;
      wait_grant(vecs[i].id, $sformatf("v%0d_grant", i));
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      bus.req_a     = {$urandom, $urandom};
      bus.req_b     = {$urandom, $urandom};
      bus.req_op    = 4'($urandom_range(0, 15));
      wait_rsp(lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_op_a_hold", i), 64'(op_a), 64'(vecs[i].a));
      check_rsp($sformatf("v%0d", i));
      @(posedge clk);
      @(negedge clk);
      exp_count++;
      chk($sformatf("v%0d_op_count", i), 64'(op_count), 64'(exp_count));
      chk($sformatf("v%0d_div_starts", i), 64'(div_starts - s0),
          64'((vecs[i].op == 2'b10) ? 1 : 0));
    end

    // ---- both lanes valid from reset: grants alternate 0,1,0 ----
    apply_reset();
    grant_seq[0] = 2'b01;
    grant_seq[1] = 2'b10;
    grant_seq[2] = 2'b01;
    exp_q.push_back('{data:32'h0006_0000, id:1'b0, err:1'b0});
    exp_q.push_back('{data:32'h0005_0000, id:1'b1, err:1'b0});
    exp_q.push_back('{data:32'h0006_0000, id:1'b0, err:1'b0});
    @(negedge clk);
    drive_req(1'b0, 2'b01, 32'h0002_0000, 32'h0003_0000);
    drive_req(1'b1, 2'b00, 32'h0002_0000, 32'h0003_0000);
    #1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(grant_seq[k][1], $sformatf("rr%0d_grant", k));
      @(posedge clk);
      #1;
      if (k == 2) bus.req_valid = 2'b00;
      wait_rsp(lat);
      chk($sformatf("rr%0d_lat", k), 64'(lat), 64'(2));
      chk($sformatf("rr%0d_busy_ready", k), 64'(bus.req_ready), 64'(2'b00));
      check_rsp($sformatf("rr%0d", k));
      exp_count++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rr_op_count", 64'(op_count), 64'(exp_count));

    // ---- response stall: 10 cycles of rsp_ready=0 with lane 1 knocking ----
    exp_q.push_back('{data:32'h0003_0000, id:1'b0, err:1'b0});
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 2'b00, 32'h0001_0000, 32'h0002_0000);
    #1;
    wait_grant(1'b0, "stall_grant");
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    drive_req(1'b1, 2'b01, 32'h0004_0000, 32'h0004_0000);
    wait_rsp(lat);
    chk("stall_lat", 64'(lat), 64'(2));
    cnt0 = op_count;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_vld", c),   64'(bus.rsp_valid), 64'(1'b1));
      chk($sformatf("stall%0d_data", c),  64'(bus.rsp_data),  64'(32'h0003_0000));
      chk($sformatf("stall%0d_ready", c), 64'(bus.req_ready), 64'(2'b00));
    end
    chk("stall_count_hold", 64'(op_count), 64'(cnt0));
    bus.rsp_ready = 1'b1;
    check_rsp("stall");
    @(posedge clk);
    #1;
    chk("stall_idle_ready", 64'(bus.req_ready), 64'(2'b10));
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("stall_vld_drop", 64'(bus.rsp_valid), 64'(1'b0));
    chk("stall_count_inc", 64'(op_count), 64'(cnt0 + 16'd1));
    repeat (3) @(negedge clk);
    chk("stall_count_once", 64'(op_count), 64'(cnt0 + 16'd1));

    // ---- reset during WAIT_DIV, late div_complete afterwards ----
    s0 = div_starts;
    @(negedge clk);
    drive_req(1'b1, 2'b10, 32'h0006_0000, 32'h0002_0000);
    #1;
    wait_grant(1'b1, "rdiv_grant");
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen++;
    end
    exp_count = 0;
    chk("midrst_no_rsp",    64'(seen),              64'(0));
    chk("midrst_starts",    64'(div_starts - s0),   64'(1));
    chk("midrst_data_zero", 64'(bus.rsp_data),      64'(0));
    chk("midrst_count",     64'(op_count),          64'(0));

    // ---- divider that never completes ----
    div_auto = 1'b0;
    @(negedge clk);
`ifdef FXP_SCHED_DIV_TIMEOUT_EN
    exp_q.push_back('{data:32'h0000_0000, id:1'b0, err:1'b1});
    drive_req(1'b0, 2'b10, 32'h0006_0000, 32'h0002_0000);
    #1;
    wait_grant(1'b0, "tmo_grant");
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    wait_rsp(lat);
    chk("tmo_lat", 64'(lat), 64'(2 + TMO));
    check_rsp("tmo");
    @(posedge clk);
    @(negedge clk);
    chk("tmo_op_count", 64'(op_count), 64'(1));
`else
    drive_req(1'b0, 2'b10, 32'h0006_0000, 32'h0002_0000);
    #1;
    wait_grant(1'b0, "hang_grant");
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    drive_req(1'b1, 2'b00, 32'h0001_0000, 32'h0001_0000);
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1 || bus.req_ready !== 2'b00) seen++;
    end
    chk("hang_still_waiting", 64'(seen), 64'(0));
    apply_reset();
`endif
    div_auto = 1'b1;

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fxp_op_scheduler.md
Name: fxp_op_scheduler

Overview:
- Sequences the shared fixed-point arithmetic datapath (adder, multiplier, multi-cycle divider) between two requesters.
- Arbitrates the requesters round-robin and drives operands and the divider start pulse.
- Waits for the divider completion and returns each result tagged with its requester ID.
- One operation in flight at a time; sits between client logic and the arithmetic units.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DIV_TIMEOUT, 64, max cycles waiting for div_complete (used only with the optional feature).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_a  in  2*WIDTH  operand A per requester; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operand B per requester, same packing.
- req_op  in  4  2-bit opcode per requester: 00 add, 01 mul, 10 div, 11 invalid.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  WIDTH  result.
- rsp_id  out  1  requester that issued the op.
- rsp_err  out  1  invalid opcode or timeout.
- op_a, op_b  out  WIDTH  registered operands to all units.
- div_start  out  1  one-cycle divider start pulse.
- add_result, mul_result  in  WIDTH  combinational unit outputs.
- div_result  in  WIDTH  divider quotient.
- div_complete  in  1  divider done.
- op_count  out  16  completed responses, wraps 0xFFFF->0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, op_a=op_b=0, div_start=0, op_count=0, RR pointer=0.
- FSM states: IDLE, EXEC, WAIT_DIV, RESP.
- IDLE:
  - req_ready is combinational from req_valid and the pointer.
  - Only one valid: grant it.
  - Both valid: grant the pointer's requester.
  - On valid&ready: latch a->op_a, b->op_b, opcode, id; go EXEC.
  - Pointer becomes ~granted_id on each grant.
- EXEC (one cycle):
  - add: capture add_result into rsp_data, err=0, go RESP.
  - mul: capture mul_result, err=0, go RESP.
  - div: div_start=1 this cycle only, go WAIT_DIV.
  - 11: rsp_data=0, err=1, go RESP.
- WAIT_DIV:
  - Hold op_a/op_b stable.
  - On div_complete=1: capture div_result, err=0, go RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id, rsp_err held stable until rsp_valid&rsp_ready.
  - Then: op_count += 1, rsp_valid=0 next cycle, go IDLE.
  - No new request is accepted in the cycle the response retires.
- Latency from accept edge to rsp_valid:
  - add/mul/invalid: 2 cycles.
  - div: 2 + divider cycles.
- req_ready=0 in every state except IDLE. div_complete is ignored outside WAIT_DIV.
- rsp_ready held low stalls in RESP indefinitely; no data loss.
- Reset mid-operation: immediate return to IDLE; in-flight op is dropped. A late div_complete after reset is ignored.
- Opcode, operand and id changes on non-granted inputs have no effect.

Optional Feature:
- Macro: FXP_SCHED_DIV_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_DIV.
  - If DIV_TIMEOUT cycles elapse without div_complete, go RESP with rsp_data=0, rsp_err=1.
  - div_complete on the same cycle as expiry wins (normal result).
- Undefined: no counter; WAIT_DIV waits forever for div_complete.

Test Plan:
- Req0 add a=0x00010000, b=0x00020000, add_result model=0x00030000, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=0x00030000, rsp_id=0, err=0, op_count=1.
- Both valid from reset (req0 mul, req1 add) -> grants in order 0 then 1. Second op is accepted only after the first response retires; rsp_id sequence 0,1.
- Req1 div a=0x00060000, b=0x00020000, divider model completes 20 cycles after start -> exactly one div_start pulse. rsp_data=0x00030000 after complete, rsp_id=1.
- Req0 opcode 11 -> rsp_err=1, rsp_data=0 after 2 cycles; no div_start.
- Hold rsp_ready=0 for 10 cycles during RESP -> rsp fields stable, req_ready=0 throughout. Release -> IDLE next cycle, op_count increments once.
- Assert rst_n=0 during WAIT_DIV, then pulse div_complete after release -> all outputs at reset values, no response produced. With FXP_SCHED_DIV_TIMEOUT_EN and no complete -> err response at DIV_TIMEOUT=64 cycles.
